// File: rtl/sync_fifo_rd_stage_if.sv
// Stream bundle between a sync_fifo read port, the read stage and its consumer.
// master = the read stage; slave = FIFO/consumer side (or a testbench).
interface sync_fifo_rd_stage_if #(
    parameter int DATAWIDTH = 96
);
    logic [DATAWIDTH-1:0] fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic                 out_valid;
    logic [DATAWIDTH-1:0] out_data;
    logic                 out_ready;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/sync_fifo_rd_stage.sv
// Registered read stage for a non-registered sync_fifo: main + skid buffer, 1 word/clk.
// Optional saturating stall/transfer counters enabled by SYNC_FIFO_RD_STAGE_STATS_EN.
module sync_fifo_rd_stage #(
    parameter int DATAWIDTH = 96,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sync_fifo_rd_stage_if.master bus,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                 pop;
    logic                 take;
    logic                 vld_p0;
    logic                 ld_main_fifo;
    logic                 ld_main_skid;
    logic                 ld_skid;
    logic [DATAWIDTH-1:0] main_p0;
    logic [DATAWIDTH-1:0] skid_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    // pop never looks at out_ready, so the consumer has no combinational path to rd_en
    always_comb begin
        vld_p0       = (state != S_EMPTY);
        pop          = rst_n & ~bus.fifo_empty & (state != S_TWO);
        take         = vld_p0 & bus.out_ready;
        ld_main_fifo = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            S_EMPTY: ld_main_fifo = pop;
            S_ONE: begin
                ld_main_fifo = take & pop;
                ld_skid      = ~take & pop;
            end
            S_TWO:   ld_main_skid = take;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (pop) state_nxt = S_ONE;
            S_ONE: begin
                if (take && !pop)      state_nxt = S_EMPTY;
                else if (!take && pop) state_nxt = S_TWO;
            end
            S_TWO:   if (take) state_nxt = S_ONE;
            default: state_nxt = S_EMPTY;
        endcase
    end

    // stage boundary: FIFO word -> main (p0) / skid (p1); loads only ever follow a real pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_p0 <= '0;
            skid_p1 <= '0;
        end else begin
            if (ld_main_fifo)      main_p0 <= bus.fifo_dout;
            else if (ld_main_skid) main_p0 <= skid_p1;
            if (ld_skid)           skid_p1 <= bus.fifo_dout;
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.out_valid  = vld_p0;
    assign bus.out_data   = main_p0;

`ifdef SYNC_FIFO_RD_STAGE_STATS_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (vld_p0 && !bus.out_ready) stall_cnt <= sat_inc(stall_cnt);
            if (take)                     xfer_cnt  <= sat_inc(xfer_cnt);
        end
    end
`else
    assign stall_cnt = '0;
    assign xfer_cnt  = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_rd_stage.sv
// Scoreboard bench for sync_fifo_rd_stage with a behavioural non-registered FIFO in front.
// Stats expectations follow SYNC_FIFO_RD_STAGE_STATS_EN at compile time.
module tb_sync_fifo_rd_stage;

    localparam int DW = 96;
    localparam int CW = 4;
    typedef logic [DW-1:0] word_t;

`ifdef SYNC_FIFO_RD_STAGE_STATS_EN
    localparam int EXP_STALL = 15;
    localparam int EXP_XFER  = 3;
`else
    localparam int EXP_STALL = 0;
    localparam int EXP_XFER  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] xfer_cnt;

    sync_fifo_rd_stage_if #(.DATAWIDTH(DW)) bus ();

    sync_fifo_rd_stage #(.DATAWIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .stall_cnt(stall_cnt),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    word_t fifo_q[$];
    word_t exp_q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    n_pops = 0;
    int    n_deliv = 0;
    logic  s_pop, s_valid, s_take;
    word_t s_data;
    logic  prev_hold = 1'b0;
    word_t prev_data = '0;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_fifo();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_dout  = (fifo_q.size() == 0) ? 'x : fifo_q[0];
    endtask

    task automatic push(input word_t w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        drive_fifo();
    endtask

    // sample on the falling edge, then retire the FIFO pop just after the rising edge
    task automatic tick();
        word_t w;
        @(negedge clk);
        s_pop   = bus.fifo_rd_en;
        s_valid = bus.out_valid;
        s_take  = bus.out_valid & bus.out_ready;
        s_data  = bus.out_data;
        if (prev_hold) begin
            check("hold_valid", word_t'(s_valid), word_t'(1));
            check("hold_data", s_data, prev_data);
        end
        if (s_take) begin
            check("sb_avail", word_t'(exp_q.size() > 0), word_t'(1));
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("order", s_data, w);
            end
            n_deliv++;
        end
        prev_hold = s_valid & ~bus.out_ready;
        prev_data = s_data;
        @(posedge clk);
        #1;
        if (s_pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            n_pops++;
        end
        drive_fifo();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        prev_hold = 1'b0;
        drive_fifo();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, first, last, nt;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        fifo_q.push_back(word_t'(96'hDEAD));
        drive_fifo();
        #3;
        check("rst_valid", word_t'(bus.out_valid), word_t'(0));
        check("rst_rd_en", word_t'(bus.fifo_rd_en), word_t'(0));
        check("rst_data", bus.out_data, word_t'(0));
        check("rst_stall", word_t'(stall_cnt), word_t'(0));
        check("rst_xfer", word_t'(xfer_cnt), word_t'(0));
        do_reset();

        // streaming with constant ready
        bus.out_ready = 1'b1;
        push(word_t'(96'hA)); push(word_t'(96'hB)); push(word_t'(96'hC));
        base = n_deliv;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("t1_pop%0d", c), word_t'(s_pop), word_t'(c < 3));
            check($sformatf("t1_valid%0d", c), word_t'(s_valid), word_t'(c >= 1 && c <= 3));
        end
        check("t1_deliv", word_t'(n_deliv - base), word_t'(3));

        // backpressure: only two words leave the FIFO
        bus.out_ready = 1'b0;
        n_pops = 0;
        for (int i = 0; i < 5; i++) push(word_t'(96'h100 + i));
        for (int c = 0; c < 4; c++) tick();
        check("t2_pops", word_t'(n_pops), word_t'(2));
        check("t2_rd_en", word_t'(s_pop), word_t'(0));
        check("t2_valid", word_t'(s_valid), word_t'(1));
        check("t2_held", s_data, word_t'(96'h100));
        check("t2_fifo_left", word_t'(fifo_q.size()), word_t'(3));
        bus.out_ready = 1'b1;
        first = -1; last = -1; nt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (s_take) begin
                if (first < 0) first = c;
                last = c;
                nt++;
            end
        end
        check("t2_takes", word_t'(nt), word_t'(5));
        check("t2_nogap", word_t'(last - first + 1), word_t'(5));

        // toggling ready
        base = n_deliv;
        for (int i = 0; i < 8; i++) push(word_t'(96'h300 + i));
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            bus.out_ready = (i % 2 == 0);
            tick();
        end
        check("t3_done", word_t'(exp_q.size()), word_t'(0));
        check("t3_deliv", word_t'(n_deliv - base), word_t'(8));

        // empty FIFO: nothing moves
        for (int c = 0; c < 20; c++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            check("t4_valid", word_t'(s_valid), word_t'(0));
            check("t4_rd_en", word_t'(s_pop), word_t'(0));
        end

        // async reset while holding two words
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(word_t'(96'h200 + i));
        for (int c = 0; c < 3; c++) tick();
        check("t5_two_rd_en", word_t'(s_pop), word_t'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", word_t'(bus.out_valid), word_t'(0));
        check("t5_rst_rd_en", word_t'(bus.fifo_rd_en), word_t'(0));
        check("t5_rst_data", bus.out_data, word_t'(0));
        do_reset();
        base = n_deliv;
        push(word_t'(96'h1));
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        check("t5_deliv", word_t'(n_deliv - base), word_t'(1));

        // statistics counters
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(word_t'(96'h400 + i));
        for (int c = 0; c < 20; c++) tick();
        check("t6_stall", word_t'(stall_cnt), word_t'(EXP_STALL));
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        check("t6_xfer", word_t'(xfer_cnt), word_t'(EXP_XFER));
        check("t6_stall_kept", word_t'(stall_cnt), word_t'(EXP_STALL));
        check("t6_drained", word_t'(exp_q.size()), word_t'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
